// File: rtl/team_select_if.sv
// Bus between the game logic and the party-selection stage: player/engine
// inputs toward the selector, party and status outputs back to the renderer/engine.
interface team_select_if;
  logic       enable;
  logic [7:0] keycode;
  logic       end_battle;
  logic       result;
  logic [8:0] team;
  logic       is_battle;
  logic [2:0] cursor;
  logic [7:0] picked_mask;
  logic [1:0] num_picked;
  logic [3:0] wins;
  logic [2:0] state_out;

  modport master (
    output enable, keycode, end_battle, result,
    input  team, is_battle, cursor, picked_mask, num_picked, wins, state_out
  );

  modport slave (
    input  enable, keycode, end_battle, result,
    output team, is_battle, cursor, picked_mask, num_picked, wins, state_out
  );
endinterface

// File: rtl/team_select.sv
// Pre-battle party selection: cursor over a COLS x 2 species grid, three distinct
// picks, then a level battle request held until the engine reports completion.
module team_select #(
  parameter int         COLS      = 4,
  parameter logic [7:0] BACKSPACE = 8'h2A
) (
  input logic          Clk,
  input logic          Reset,
  team_select_if.slave bus
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PICK    = 3'd1,
    CONFIRM = 3'd2,
    BATTLE  = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      prev_key_q;
  logic            row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [8:0]      team_q, team_d;
  logic [7:0]      mask_q, mask_d;
  logic [1:0]      num_q, num_d;
  logic [3:0]      wins_q, wins_d;

  logic            press;
  logic            clear_sel;
  logic [2:0]      cursor_id;
  logic [1:0]      last_slot;
  logic [2:0]      last_id;

  assign press     = (bus.keycode != 8'd0) && (bus.keycode != prev_key_q);
  assign cursor_id = 3'(int'(row_q) * COLS + int'(col_q));
  // Slot and species that a backspace would remove; only meaningful when num_q > 0.
  assign last_slot = num_q - 2'd1;
  assign last_id   = team_q[3*last_slot +: 3];

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    team_d    = team_q;
    mask_d    = mask_q;
    num_d     = num_q;
    wins_d    = wins_q;
    clear_sel = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d   = PICK;
          clear_sel = 1'b1;
        end
      end

      PICK: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (press) begin
          case (bus.keycode)
            KEY_W: if (row_q)  row_d = 1'b0;
            KEY_S: if (!row_q) row_d = 1'b1;
            KEY_A: if (col_q != '0) col_d = col_q - CW'(1);
            KEY_D: if (int'(col_q) < COLS - 1) col_d = col_q + CW'(1);
            KEY_ENTER: begin
              if (!mask_q[cursor_id] && (num_q != 2'd3)) begin
                team_d[3*num_q +: 3] = cursor_id;
                mask_d[cursor_id]    = 1'b1;
                num_d                = num_q + 2'd1;
                if (num_q == 2'd2) state_d = CONFIRM;
              end
            end
            BACKSPACE: begin
              if (num_q != 2'd0) begin
                team_d[3*last_slot +: 3] = 3'd0;
                mask_d[last_id]          = 1'b0;
                num_d                    = last_slot;
              end
            end
            default: ;
          endcase
        end
      end

      CONFIRM: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (press && (bus.keycode == KEY_ENTER)) begin
          state_d = BATTLE;
        end else if (press && (bus.keycode == BACKSPACE)) begin
          team_d[3*last_slot +: 3] = 3'd0;
          mask_d[last_id]          = 1'b0;
          num_d                    = last_slot;
          state_d                  = PICK;
        end
      end

      BATTLE: begin
        if (bus.end_battle) begin
          if (bus.result && (wins_q != 4'hF)) wins_d = wins_q + 4'd1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (press && (bus.keycode == KEY_ENTER)) begin
          state_d   = PICK;
          clear_sel = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Entering a fresh selection starts from an empty party with the cursor home.
    if (clear_sel) begin
      team_d = 9'd0;
      mask_d = 8'd0;
      num_d  = 2'd0;
      row_d  = 1'b0;
      col_d  = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      prev_key_q <= 8'd0;
      row_q      <= 1'b0;
      col_q      <= '0;
      team_q     <= 9'd0;
      mask_q     <= 8'd0;
      num_q      <= 2'd0;
      wins_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      prev_key_q <= bus.keycode;
      row_q      <= row_d;
      col_q      <= col_d;
      team_q     <= team_d;
      mask_q     <= mask_d;
      num_q      <= num_d;
      wins_q     <= wins_d;
    end
  end

  assign bus.team        = team_q;
  assign bus.is_battle   = (state_q == BATTLE);
  assign bus.cursor      = cursor_id;
  assign bus.picked_mask = mask_q;
  assign bus.num_picked  = num_q;
  assign bus.wins        = wins_q;
  assign bus.state_out   = state_q;

endmodule
